// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding and constants for the interrupt sequencer
package cpu_pkg;
  typedef enum logic [2:0] {IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, DONE} state_t;
  localparam logic [3:0] ACK_NMI = 4'hF;
  localparam logic [7:0] STACK_PAGE = 8'h01;
  localparam int B_BIT = 4;
  localparam int U_BIT = 5;
  function automatic logic [7:0] push_flags(input logic [7:0] f);
    logic [7:0] r;
    r = f;
    r[B_BIT] = 1'b0;
    r[U_BIT] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: memory bus taken over by the sequencer while busy
interface interrupt_sequencer_if;
  logic busy;
  logic [15:0] address;
  logic [7:0] data_write;
  logic [7:0] data_read;
  logic read_write;
  modport master(output busy, address, data_write, read_write, input data_read);
  modport slave(input busy, address, data_write, read_write, output data_read);
endinterface

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: valid + index of the lowest set request bit
module irq_priority_encoder #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);
  always_comb begin
    valid = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) begin
        valid = 1'b1;
        idx = 4'(i);
      end
  end
endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: prioritised IRQ/NMI entry, pushes PC/P and fetches the vector
module interrupt_sequencer
  import cpu_pkg::*;
#(
  parameter int          N_IRQ = 4,
  parameter logic [15:0] IRQ_VEC_BASE = 16'hFFF0,
  parameter logic [15:0] NMI_VEC = 16'hFFFA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IRQ-1:0]     irq,
  input  logic [N_IRQ-1:0]     irq_mask,
  input  logic                 nmi_n,
  input  logic                 instr_boundary,
  input  logic                 i_flag,
  input  logic [15:0]          pc,
  input  logic [7:0]           sp,
  input  logic [7:0]           flags,
  interrupt_sequencer_if.master bus,
  output logic                 pc_load,
  output logic [15:0]          pc_new,
  output logic                 sp_load,
  output logic [7:0]           sp_new,
  output logic                 i_set,
  output logic [3:0]           ack_id
);
  state_t state;
  logic nmi_prev, nmi_pend, nmi_req, irq_valid, accept;
  logic [3:0] irq_idx, src;
  logic [15:0] pc_l, vec;
  logic [7:0] sp_l, flags_l;
  logic [N_IRQ-1:0] eligible;
  assign eligible = i_flag ? '0 : irq & irq_mask;
  irq_priority_encoder #(.N(N_IRQ)) u_enc (.req(eligible), .valid(irq_valid), .idx(irq_idx));
  // an edge arriving on the acceptance edge itself still beats any IRQ
  assign nmi_req = nmi_pend | (nmi_prev & ~nmi_n);
  assign accept = state == IDLE && instr_boundary && (nmi_req || irq_valid);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      nmi_prev <= 1'b1;
      nmi_pend <= 1'b0;
      src <= '0;
      vec <= '0;
      pc_l <= '0;
      sp_l <= '0;
      flags_l <= '0;
      bus.busy <= 1'b0;
      bus.address <= '0;
      bus.data_write <= '0;
      bus.read_write <= 1'b1;
      pc_load <= 1'b0;
      sp_load <= 1'b0;
      i_set <= 1'b0;
      pc_new <= '0;
      sp_new <= '0;
      ack_id <= '0;
    end else begin
      nmi_prev <= nmi_n;
      nmi_pend <= nmi_req & ~accept;
      pc_load <= 1'b0;
      sp_load <= 1'b0;
      i_set <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state <= PUSH_H;
          src <= nmi_req ? ACK_NMI : irq_idx;
          vec <= nmi_req ? NMI_VEC : IRQ_VEC_BASE + {11'd0, irq_idx, 1'b0};
          pc_l <= pc;
          sp_l <= sp;
          flags_l <= flags;
          bus.busy <= 1'b1;
          bus.address <= {STACK_PAGE, sp};
          bus.data_write <= pc[15:8];
          bus.read_write <= 1'b0;
        end
        PUSH_H: begin
          state <= PUSH_L;
          bus.address <= {STACK_PAGE, sp_l - 8'd1};
          bus.data_write <= pc_l[7:0];
        end
        PUSH_L: begin
          state <= PUSH_P;
          bus.address <= {STACK_PAGE, sp_l - 8'd2};
          bus.data_write <= push_flags(flags_l);
        end
        PUSH_P: begin
          state <= VEC_L;
          bus.address <= vec;
          bus.data_write <= '0;
          bus.read_write <= 1'b1;
        end
        VEC_L: begin
          state <= VEC_H;
          pc_new[7:0] <= bus.data_read;
          bus.address <= vec + 16'd1;
        end
        VEC_H: begin
          state <= DONE;
          pc_new[15:8] <= bus.data_read;
          bus.busy <= 1'b0;
          bus.address <= '0;
          pc_load <= 1'b1;
          sp_load <= 1'b1;
          i_set <= 1'b1;
          sp_new <= sp_l - 8'd3;
          ack_id <= src;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: table, random and corner-case checks against a transaction-level model
module tb_interrupt_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] irq, irq_mask;
  logic nmi_n, instr_boundary, i_flag;
  logic [15:0] pc;
  logic [7:0] sp, flags;
  logic pc_load, sp_load, i_set;
  logic [15:0] pc_new;
  logic [7:0] sp_new;
  logic [3:0] ack_id;
  int n_checks = 0;
  int n_fail = 0;
  int load_cnt = 0;
  logic [15:0] wa[$];
  logic [7:0] wd[$];
  logic [15:0] ra[$];
  interrupt_sequencer_if bus();
  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .irq(irq), .irq_mask(irq_mask), .nmi_n(nmi_n),
    .instr_boundary(instr_boundary), .i_flag(i_flag), .pc(pc), .sp(sp), .flags(flags),
    .bus(bus), .pc_load(pc_load), .pc_new(pc_new), .sp_load(sp_load), .sp_new(sp_new),
    .i_set(i_set), .ack_id(ack_id)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] rd(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction
  always_comb bus.data_read = rd(bus.address);
  // bus monitor: record every transfer the sequencer makes
  always @(negedge clk) begin
    if (bus.busy && !bus.read_write) begin
      wa.push_back(bus.address);
      wd.push_back(bus.data_write);
    end
    if (bus.busy && bus.read_write) ra.push_back(bus.address);
    if (pc_load) load_cnt++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic serve(input logic [3:0] src, input logic [15:0] pcv, input logic [7:0] spv,
                       input logic [7:0] fv);
    int busy_cnt;
    bit seen;
    logic [15:0] v;
    logic [15:0] ea[3];
    logic [7:0] ed[3];
    busy_cnt = 0;
    seen = 0;
    wa.delete();
    wd.delete();
    ra.delete();
    v = (src == 4'hF) ? 16'hFFFA : 16'hFFF0 + 16'(2 * src);
    for (int i = 0; i < 3; i++) ea[i] = {8'h01, 8'(spv - 8'(i))};
    ed[0] = pcv[15:8];
    ed[1] = pcv[7:0];
    ed[2] = (fv & 8'hEF) | 8'h20;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 0) begin
        instr_boundary = 1'b0;
        pc = 16'($urandom);
        sp = 8'($urandom);
        flags = 8'($urandom);
      end
      if (bus.busy) busy_cnt++;
      if (pc_load) seen = 1;
    end
    chk("done_seen", 32'(seen), 1);
    chk("busy_cycles", busy_cnt, 5);
    chk("busy_at_done", 32'(bus.busy), 0);
    chk("sp_load_i_set", {sp_load, i_set}, 2'b11);
    chk("ack_id", ack_id, src);
    chk("pc_new", pc_new, {rd(v + 16'd1), rd(v)});
    chk("sp_new", sp_new, 8'(spv - 8'd3));
    chk("n_writes", wa.size(), 3);
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      chk("push_addr", wa[i], ea[i]);
      chk("push_data", wd[i], ed[i]);
    end
    chk("n_reads", ra.size(), 2);
    if (ra.size() == 2) begin
      chk("vec_lo_addr", ra[0], v);
      chk("vec_hi_addr", ra[1], v + 16'd1);
    end
    @(negedge clk);
    chk("pulse_width", {pc_load, sp_load, i_set}, 3'b000);
  endtask
  task automatic no_accept(input string name);
    bit saw;
    int base;
    saw = 0;
    base = load_cnt;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      instr_boundary = 1'b0;
      if (bus.busy) saw = 1;
    end
    chk(name, {31'(load_cnt - base), saw}, 0);
  endtask
  task automatic do_case(input logic [3:0] q, input logic [3:0] m, input logic f,
                         input logic [15:0] pcv, input logic [7:0] spv, input logic [7:0] fv,
                         input logic acc, input logic [3:0] ack);
    irq = q;
    irq_mask = m;
    i_flag = f;
    pc = pcv;
    sp = spv;
    flags = fv;
    instr_boundary = 1'b1;
    if (acc) serve(ack, pcv, spv, fv);
    else no_accept("no_accept");
    irq = '0;
    @(negedge clk);
  endtask
  typedef struct {
    logic [3:0] irq, mask;
    logic iflag;
    logic [15:0] pc;
    logic [7:0] sp, flags;
    logic acc;
    logic [3:0] ack;
  } vec_t;
  vec_t tbl[7];
  initial begin
    int base;
    logic [3:0] q, m, elig, exp_ack;
    logic f;
    tbl[0] = '{4'b0100, 4'hF, 1'b0, 16'h1234, 8'hFD, 8'h30, 1'b1, 4'd2};
    tbl[1] = '{4'b1010, 4'hF, 1'b0, 16'hABCD, 8'h80, 8'hFF, 1'b1, 4'd1};
    tbl[2] = '{4'b1010, 4'hF, 1'b1, 16'h5555, 8'h80, 8'h04, 1'b0, 4'd0};
    tbl[3] = '{4'b1111, 4'h0, 1'b0, 16'h2222, 8'h10, 8'h00, 1'b0, 4'd0};
    tbl[4] = '{4'b1100, 4'b1000, 1'b0, 16'h0000, 8'h01, 8'h00, 1'b1, 4'd3};
    tbl[5] = '{4'b0001, 4'b0001, 1'b0, 16'hFFFF, 8'h00, 8'h10, 1'b1, 4'd0};
    tbl[6] = '{4'b1111, 4'b1110, 1'b0, 16'h4000, 8'h02, 8'hEF, 1'b1, 4'd1};
    rst = 1'b0;
    irq = '0;
    irq_mask = '0;
    nmi_n = 1'b1;
    instr_boundary = 1'b0;
    i_flag = 1'b0;
    pc = '0;
    sp = '0;
    flags = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus", {bus.busy, bus.address, bus.data_write, bus.read_write}, {1'b0, 16'h0, 8'h0, 1'b1});
    chk("rst_pulses", {pc_load, sp_load, i_set}, 3'b000);
    chk("rst_vals", {pc_new, sp_new, ack_id}, 28'h0);
    rst = 1'b1;
    @(negedge clk);
    foreach (tbl[i])
      do_case(tbl[i].irq, tbl[i].mask, tbl[i].iflag, tbl[i].pc, tbl[i].sp, tbl[i].flags,
              tbl[i].acc, tbl[i].ack);
    for (int n = 0; n < 40; n++) begin
      q = 4'($urandom);
      m = 4'($urandom);
      f = ($urandom_range(0, 3) == 0);
      elig = f ? 4'h0 : q & m;
      exp_ack = 4'd0;
      for (int k = 3; k >= 0; k--) if (elig[k]) exp_ack = 4'(k);
      do_case(q, m, f, 16'($urandom), 8'($urandom), 8'($urandom), elig != 0, exp_ack);
    end
    // NMI edge together with an eligible IRQ0
    irq = 4'b0001;
    irq_mask = 4'hF;
    i_flag = 1'b0;
    nmi_n = 1'b0;
    instr_boundary = 1'b1;
    serve(4'hF, pc, sp, flags);
    no_accept("irq_waits_boundary");
    instr_boundary = 1'b1;
    serve(4'h0, pc, sp, flags);
    irq = '0;
    nmi_n = 1'b1;
    repeat (2) @(negedge clk);
    // NMI held low is one event; a second edge mid-sequence queues another
    base = load_cnt;
    instr_boundary = 1'b1;
    nmi_n = 1'b0;
    repeat (25) @(negedge clk);
    chk("nmi_hold_count", load_cnt - base, 1);
    chk("nmi_hold_ack", ack_id, 4'hF);
    nmi_n = 1'b1;
    @(negedge clk);
    base = load_cnt;
    nmi_n = 1'b0;
    @(negedge clk);
    chk("nmi2_busy", 32'(bus.busy), 1);
    nmi_n = 1'b1;
    @(negedge clk);
    nmi_n = 1'b0;
    repeat (25) @(negedge clk);
    chk("nmi_twice_count", load_cnt - base, 2);
    instr_boundary = 1'b0;
    nmi_n = 1'b1;
    repeat (2) @(negedge clk);
    // reset during PUSH_L with an NMI pending
    base = load_cnt;
    irq = 4'b0001;
    irq_mask = 4'hF;
    sp = 8'h40;
    instr_boundary = 1'b1;
    @(negedge clk);
    instr_boundary = 1'b0;
    nmi_n = 1'b0;
    @(negedge clk);
    chk("pushl_addr", bus.address, 16'h013F);
    rst = 1'b0;
    nmi_n = 1'b1;
    irq = '0;
    @(negedge clk);
    chk("midrst_bus", {bus.busy, bus.read_write, bus.address}, {1'b0, 1'b1, 16'h0});
    chk("midrst_pulses", {pc_load, sp_load, i_set}, 3'b000);
    rst = 1'b1;
    instr_boundary = 1'b1;
    no_accept("midrst_pend_cleared");
    chk("midrst_no_load", load_cnt - base, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
